// File: rtl/ctrl_encode_def.sv
// ---------------------------------------------------------------------------
// ctrl_encode_def
// Shared encodings for the pipeline hazard logic:
//   - md_state_e : mult/div occupancy FSM states (RUN, MD_WAIT)
//   - *_ON/*_OFF : polarity of each pipeline control line
//   - pipe_ctrl_t: bundle of the four pipeline controls, plus one constant
//                  per control mode (redirect, stall, fetch wait, run)
//   - src_hit    : "this source operand reads register dst" helper
// ---------------------------------------------------------------------------
package ctrl_encode_def;

    localparam int MD_CNT_W = 6;

    typedef enum logic {
        RUN     = 1'b0,
        MD_WAIT = 1'b1
    } md_state_e;

    localparam logic PC_WRITE_ON     = 1'b1;
    localparam logic PC_WRITE_OFF    = 1'b0;
    localparam logic IF_ID_WRITE_ON  = 1'b1;
    localparam logic IF_ID_WRITE_OFF = 1'b0;
    localparam logic IF_ID_FLUSH_ON  = 1'b1;
    localparam logic IF_ID_FLUSH_OFF = 1'b0;
    localparam logic ID_EX_FLUSH_ON  = 1'b1;
    localparam logic ID_EX_FLUSH_OFF = 1'b0;

    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic if_id_flush;
        logic id_ex_flush;
    } pipe_ctrl_t;

    // Taken branch/jump: fetch the target, squash both younger instructions.
    localparam pipe_ctrl_t CTRL_REDIRECT = '{
        pc_write:    PC_WRITE_ON,
        if_id_write: IF_ID_WRITE_OFF,
        if_id_flush: IF_ID_FLUSH_ON,
        id_ex_flush: ID_EX_FLUSH_ON
    };

    // Data hazard: hold PC and IF/ID, insert a bubble into EX.
    localparam pipe_ctrl_t CTRL_STALL = '{
        pc_write:    PC_WRITE_OFF,
        if_id_write: IF_ID_WRITE_OFF,
        if_id_flush: IF_ID_FLUSH_OFF,
        id_ex_flush: ID_EX_FLUSH_ON
    };

    // Fetch not ready: hold PC, present a bubble in IF/ID instead.
    localparam pipe_ctrl_t CTRL_FETCH_WAIT = '{
        pc_write:    PC_WRITE_OFF,
        if_id_write: IF_ID_WRITE_OFF,
        if_id_flush: IF_ID_FLUSH_ON,
        id_ex_flush: ID_EX_FLUSH_OFF
    };

    localparam pipe_ctrl_t CTRL_RUN = '{
        pc_write:    PC_WRITE_ON,
        if_id_write: IF_ID_WRITE_ON,
        if_id_flush: IF_ID_FLUSH_OFF,
        id_ex_flush: ID_EX_FLUSH_OFF
    };

    function automatic logic src_hit(input logic uses, input logic [4:0] src,
                                     input logic [4:0] dst);
        return uses && (src == dst);
    endfunction

endpackage

// File: rtl/hazard_sequencer_md_timer.sv
// ---------------------------------------------------------------------------
// md_timer
// Mult/div occupancy tracker. A mult/div accepted on an edge keeps the unit
// busy for the following MD_LATENCY-1 cycles.
// Ports:
//   clk     in   clock, rising edge
//   reset   in   asynchronous, active-high reset
//   accept  in   mult/div accepted on this edge
//   md_busy out  unit occupied (registered, equals state==MD_WAIT)
// ---------------------------------------------------------------------------
module md_timer
    import ctrl_encode_def::*;
#(
    parameter int MD_LATENCY = 32
) (
    input  logic clk,
    input  logic reset,
    input  logic accept,
    output logic md_busy
);

    localparam logic [MD_CNT_W-1:0] MD_LOAD = MD_CNT_W'(MD_LATENCY - 1);

    md_state_e           state_q;
    logic [MD_CNT_W-1:0] md_cnt_q;
    logic                md_busy_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= RUN;
            md_cnt_q  <= '0;
            md_busy_q <= 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    if (accept) begin
                        state_q   <= MD_WAIT;
                        md_cnt_q  <= MD_LOAD;
                        md_busy_q <= 1'b1;
                    end
                end
                MD_WAIT: begin
                    md_cnt_q <= md_cnt_q - MD_CNT_W'(1);
                    // Leaving on the edge where the count reads 1 gives
                    // exactly MD_LATENCY-1 busy cycles.
                    if (md_cnt_q == MD_CNT_W'(1)) begin
                        state_q   <= RUN;
                        md_busy_q <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= RUN;
                    md_busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign md_busy = md_busy_q;

endmodule

// File: rtl/hazard_sequencer.sv
// ---------------------------------------------------------------------------
// hazard_sequencer
// Pipeline hazard control for a 5-stage pipeline: load-use stalls, mult/div
// HI/LO occupancy stalls, branch redirect flushes and instruction fetch wait.
// Control priority: redirect > (load_use | md_conflict) > !imem_ready > run.
// Ports:
//   clk, reset                 clock / async active-high reset
//   id_rs, id_rt               ID source registers
//   id_uses_rs, id_uses_rt     ID instruction reads rs / rt
//   id_md_read                 ID instruction reads HI/LO
//   md_start                   ID instruction is mult/div
//   ex_mem_read, ex_rt         EX holds a load writing ex_rt
//   redirect                   taken branch/jump resolved in EX
//   imem_ready                 instruction memory data valid
//   pc_write, if_id_write,
//   if_id_flush, id_ex_flush   pipeline controls (combinational, 1 = active)
//   md_busy                    mult/div unit occupied
//   stall_cycles               saturating count of cycles with pc_write=0
// ---------------------------------------------------------------------------
module hazard_sequencer
    import ctrl_encode_def::*;
#(
    parameter int MD_LATENCY = 32,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             id_md_read,
    input  logic             md_start,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rt,
    input  logic             redirect,
    input  logic             imem_ready,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             md_busy,
    output logic [CNT_W-1:0] stall_cycles
);

    logic             load_use;
    logic             md_conflict;
    logic             md_accept;
    pipe_ctrl_t       ctrl;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d;

    // r0 is hard-wired zero, so a load targeting it never creates a hazard.
    assign load_use = ex_mem_read && (ex_rt != 5'd0) &&
                      (src_hit(id_uses_rs, id_rs, ex_rt) ||
                       src_hit(id_uses_rt, id_rt, ex_rt));

    assign md_conflict = md_busy && (id_md_read || md_start);

    always_comb begin
        ctrl = CTRL_RUN;
        if (redirect) begin
            ctrl = CTRL_REDIRECT;
        end else if (load_use || md_conflict) begin
            ctrl = CTRL_STALL;
        end else if (!imem_ready) begin
            ctrl = CTRL_FETCH_WAIT;
        end
    end

    assign pc_write    = ctrl.pc_write;
    assign if_id_write = ctrl.if_id_write;
    assign if_id_flush = ctrl.if_id_flush;
    assign id_ex_flush = ctrl.id_ex_flush;

    // A mult/div squashed by a redirect or held by a load-use stall is not
    // started; one that is already running is never cancelled.
    assign md_accept = md_start && !redirect && !load_use && !md_busy;

    md_timer #(
        .MD_LATENCY(MD_LATENCY)
    ) u_md_timer (
        .clk    (clk),
        .reset  (reset),
        .accept (md_accept),
        .md_busy(md_busy)
    );

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!ctrl.pc_write && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cycles = stall_cnt_q;

endmodule
